// File: rtl/mouse_pkg.sv
// Shared types and protocol constants for the PS/2 mouse controller.
// Optional feature macro: MOUSE_SCROLL_EN (wheel-mouse unlock sequence + 4-byte packets).
package mouse_pkg;

  typedef enum logic [3:0] {
    S_TX_RST,
    S_ACK1,
    S_BAT,
    S_ID,
    S_TX_EN,
    S_ACK2,
    S_TX_SEQ,
    S_ACK_SEQ,
    S_ID2,
    S_STREAM,
    S_ERROR
  } mouse_state_t;

  localparam logic [7:0] CMD_RESET    = 8'hFF;
  localparam logic [7:0] CMD_ENABLE   = 8'hF4;
  localparam logic [7:0] CMD_SET_RATE = 8'hF3;
  localparam logic [7:0] CMD_GET_ID   = 8'hF2;
  localparam logic [7:0] RSP_ACK      = 8'hFA;
  localparam logic [7:0] RSP_BAT      = 8'hAA;
  localparam logic [7:0] RSP_ID_STD   = 8'h00;
  localparam logic [7:0] RSP_ID_WHEEL = 8'h03;

  // Index of the last byte of the wheel unlock sequence (GET_ID)
  localparam logic [2:0] SEQ_LAST = 3'd6;

  // Wheel unlock: set rate 200, 100, 80, then ask for the device ID
  function automatic logic [7:0] scroll_cmd(input logic [2:0] i);
    case (i)
      3'd0, 3'd2, 3'd4: return CMD_SET_RATE;
      3'd1:             return 8'hC8;
      3'd3:             return 8'h64;
      3'd5:             return 8'h50;
      default:          return CMD_GET_ID;
    endcase
  endfunction

endpackage

// File: rtl/mouse_axis_accum.sv
// One cursor axis: add a signed delta to the current position and clamp
// to 0..MAX. The sum is W+2 bits signed so neither edge can wrap.
module mouse_axis_accum
  import mouse_pkg::*;
#(
  parameter int W   = 10,
  parameter int MAX = 639
) (
  input  logic [W-1:0]       cur,
  input  logic signed [9:0]  delta,
  output logic [W-1:0]       nxt
);

  localparam logic signed [W+1:0] MAXV = (W+2)'(MAX);

  logic signed [W+1:0] sum;

  // Widened add, then saturate at both ends
  always_comb begin
    sum = $signed({2'b00, cur}) + $signed({{(W-8){delta[9]}}, delta});
    if (sum[W+1])         nxt = '0;
    else if (sum > MAXV)  nxt = MAXV[W-1:0];
    else                  nxt = sum[W-1:0];
  end

endmodule

// File: rtl/mouse_ctrl.sv
// PS/2 mouse sequencer: power-up init handshake, packet assembly, clamped
// cursor and button state. Optional feature macro: MOUSE_SCROLL_EN enables the
// wheel unlock sequence, 4-byte packets and z_o; otherwise z_o is tied to 0.
module mouse_ctrl
  import mouse_pkg::*;
#(
  parameter int SCREEN_W    = 640,
  parameter int SCREEN_H    = 480,
  parameter int X_W         = 10,
  parameter int Y_W         = 9,
  parameter int RSP_TIMEOUT = 50_000_000,
  parameter int PKT_GAP     = 2_000_000,
  parameter int RETRY_MAX   = 3
) (
  input  logic           clk_i,
  input  logic           reset_i,
  output logic [7:0]     tx_data_o,
  output logic           tx_valid_o,
  input  logic           tx_ready_i,
  input  logic [7:0]     rx_data_i,
  input  logic           rx_valid_i,
  input  logic           rx_err_i,
  output logic [X_W-1:0] x_o,
  output logic [Y_W-1:0] y_o,
  output logic           btn_l_o,
  output logic           btn_r_o,
  output logic [3:0]     z_o,
  output logic           upd_o,
  output logic           init_done_o,
  output logic           err_o
);

  localparam int TW = $clog2(RSP_TIMEOUT + 1);
  localparam int GW = $clog2(PKT_GAP + 1);
  localparam int RW = $clog2(RETRY_MAX + 2);

  mouse_state_t   state, tx_next, wait_next;
  logic [TW-1:0]  tmo;
  logic [GW-1:0]  gap;
  logic [RW-1:0]  retry;
  logic [1:0]     idx, pkt_last;
  logic [5:0]     hdr;      // {yovf, xovf, ysign, xsign, btn_r, btn_l} of byte 0
  logic [7:0]     b1, c2;
  logic [7:0]     tx_byte, exp_byte;
  logic           is_tx, is_wait, match, rsp_bad;
  logic signed [9:0] dx, dy, dy_n;
  logic [X_W-1:0] x_nxt;
  logic [Y_W-1:0] y_nxt;
`ifdef MOUSE_SCROLL_EN
  logic [2:0]     seq;
  logic [7:0]     b2;
  logic           wheel;
`endif

  // Per-state command byte / expected reply and where each state goes next
  always_comb begin
    tx_byte   = CMD_RESET;
    tx_next   = S_ACK1;
    exp_byte  = RSP_ACK;
    wait_next = S_STREAM;
    case (state)
      S_TX_EN: begin tx_byte = CMD_ENABLE; tx_next = S_ACK2; end
      S_ACK1:  wait_next = S_BAT;
      S_BAT:   begin exp_byte = RSP_BAT; wait_next = S_ID; end
      S_ID:    begin exp_byte = RSP_ID_STD; wait_next = S_TX_EN; end
`ifdef MOUSE_SCROLL_EN
      S_TX_SEQ:  begin tx_byte = scroll_cmd(seq); tx_next = S_ACK_SEQ; end
      S_ACK2:    wait_next = S_TX_SEQ;
      S_ACK_SEQ: wait_next = (seq == SEQ_LAST) ? S_ID2 : S_TX_SEQ;
      S_ID2:     exp_byte = RSP_ID_STD;
`endif
      default: ;
    endcase
  end

  assign is_tx   = (state == S_TX_RST) || (state == S_TX_EN) || (state == S_TX_SEQ);
  assign is_wait = (state == S_ACK1) || (state == S_BAT) || (state == S_ID) ||
                   (state == S_ACK2) || (state == S_ACK_SEQ) || (state == S_ID2);
`ifdef MOUSE_SCROLL_EN
  assign match    = (rx_data_i == exp_byte) || ((state == S_ID2) && (rx_data_i == RSP_ID_WHEEL));
  assign pkt_last = wheel ? 2'd3 : 2'd2;
  assign c2       = (idx == 2'd3) ? b2 : rx_data_i;
`else
  assign match    = (rx_data_i == exp_byte);
  assign pkt_last = 2'd2;
  assign c2       = rx_data_i;
  assign z_o      = 4'd0;
`endif
  // A line error always beats a byte arriving in the same cycle
  assign rsp_bad = rx_err_i || (rx_valid_i && !match) || (tmo == TW'(RSP_TIMEOUT));

  // 9-bit deltas sign-extended to 10; overflowed axes contribute nothing.
  // Y is negated because PS/2 +Y is up while screen Y grows downward.
  assign dx   = hdr[4] ? 10'sd0 : $signed({{2{hdr[2]}}, b1});
  assign dy   = hdr[5] ? 10'sd0 : $signed({{2{hdr[3]}}, c2});
  assign dy_n = -dy;

  mouse_axis_accum #(.W(X_W), .MAX(SCREEN_W - 1)) u_acc_x (.cur(x_o), .delta(dx),   .nxt(x_nxt));
  mouse_axis_accum #(.W(Y_W), .MAX(SCREEN_H - 1)) u_acc_y (.cur(y_o), .delta(dy_n), .nxt(y_nxt));

  // Init handshake FSM, stream packet assembly and registered outputs
  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      state       <= S_TX_RST;
      tmo         <= '0;
      gap         <= '0;
      retry       <= '0;
      idx         <= '0;
      hdr         <= '0;
      b1          <= '0;
      tx_data_o   <= '0;
      tx_valid_o  <= 1'b0;
      x_o         <= X_W'(SCREEN_W / 2);
      y_o         <= Y_W'(SCREEN_H / 2);
      btn_l_o     <= 1'b0;
      btn_r_o     <= 1'b0;
      upd_o       <= 1'b0;
      init_done_o <= 1'b0;
      err_o       <= 1'b0;
`ifdef MOUSE_SCROLL_EN
      seq         <= '0;
      b2          <= '0;
      wheel       <= 1'b0;
      z_o         <= '0;
`endif
    end else begin
      upd_o <= 1'b0;
      if (is_tx) begin
        // Raise valid with the byte, hold both until the transceiver takes it
        if (!tx_valid_o) begin
          tx_valid_o <= 1'b1;
          tx_data_o  <= tx_byte;
        end else if (tx_ready_i) begin
          tx_valid_o <= 1'b0;
          state      <= tx_next;
          tmo        <= '0;
        end
      end else if (is_wait) begin
        if (rsp_bad) begin
          tmo <= '0;
          if (retry == RW'(RETRY_MAX)) begin
            state <= S_ERROR;
            err_o <= 1'b1;
          end else begin
            retry <= retry + RW'(1);
            state <= S_TX_RST;
          end
        end else if (rx_valid_i) begin
          state <= wait_next;
          tmo   <= '0;
          if (wait_next == S_STREAM) begin
            init_done_o <= 1'b1;
            idx         <= '0;
            gap         <= '0;
          end
`ifdef MOUSE_SCROLL_EN
          if (state == S_ACK2)    seq   <= '0;
          if (state == S_ACK_SEQ) seq   <= seq + 3'd1;
          if (state == S_ID2)     wheel <= (rx_data_i == RSP_ID_WHEEL);
`endif
        end else begin
          tmo <= tmo + TW'(1);
        end
      end else if (state == S_STREAM) begin
        if (rx_err_i) begin
          idx <= '0;
          gap <= '0;
        end else if (rx_valid_i) begin
          gap <= '0;
          if (idx == 2'd0) begin
            // Bit 3 of the header is always 1; anything else is out of sync
            if (rx_data_i[3]) begin
              hdr <= {rx_data_i[7:4], rx_data_i[1:0]};
              idx <= 2'd1;
            end
          end else if (idx == pkt_last) begin
            x_o     <= x_nxt;
            y_o     <= y_nxt;
            btn_l_o <= hdr[0];
            btn_r_o <= hdr[1];
            upd_o   <= 1'b1;
            idx     <= '0;
`ifdef MOUSE_SCROLL_EN
            z_o     <= wheel ? rx_data_i[3:0] : 4'd0;
`endif
          end else if (idx == 2'd1) begin
            b1  <= rx_data_i;
            idx <= 2'd2;
          end
`ifdef MOUSE_SCROLL_EN
          else begin
            b2  <= rx_data_i;
            idx <= 2'd3;
          end
`endif
        end else if (idx != 2'd0) begin
          // A stalled packet is abandoned so the next header resyncs
          if (gap == GW'(PKT_GAP - 1)) begin
            idx <= '0;
            gap <= '0;
          end else begin
            gap <= gap + GW'(1);
          end
        end
      end
    end
  end

endmodule
